ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding muxes; sits directly upstream of the ALU.

---
 rtl/ex_operand_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ----------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register with operand forwarding. It sits directly in front
// of the ALU. Each cycle it captures the decoded instruction fields. It then
// drives the two ALU operands and the ALU opcode. Read-after-write hazards are
// resolved from the EX/MEM and MEM/WB stages.
//
// The hazard unit can hold the stage (stall) or replace its contents with a
// bubble (flush). The priority per clock is reset > flush > stall > load.
//
// Parameters
//   DW  datapath width (matches the ALU operand width)
//   RW  register-address width
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_*                decoded instruction fields from the ID stage
//   stall, flush        hazard-unit controls
//   exmem_* / memwb_*   forwarding sources (write enable, destination, data)
//   src_A, src_B        ALU operands (combinational: stored value + forwarding)
//   ALU_control         registered ALU opcode
//   ex_valid            registered; the stage holds a real instruction
//   ex_rd_addr          registered destination address
//   ex_reg_write        stored reg_write qualified by ex_valid
//   ex_rt_data          forwarded rt operand (store data), taken before the
//                       immediate mux
// ----------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic [3:0]    id_alu_ctrl,
    input  logic          id_reg_write,

    input  logic          stall,
    input  logic          flush,

    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,

    output logic [DW-1:0] src_A,
    output logic [DW-1:0] src_B,
    output logic [3:0]    ALU_control,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_reg_write,
    output logic [DW-1:0] ex_rt_data
);

    // ------------------------------------------------------------------------
    // Stored stage fields
    // ------------------------------------------------------------------------
    logic          valid_q,     valid_d;
    logic [RW-1:0] rs_addr_q,   rs_addr_d;
    logic [RW-1:0] rt_addr_q,   rt_addr_d;
    logic [RW-1:0] rd_addr_q,   rd_addr_d;
    logic [DW-1:0] rs_data_q,   rs_data_d;
    logic [DW-1:0] rt_data_q,   rt_data_d;
    logic [DW-1:0] imm_q,       imm_d;
    logic          use_imm_q,   use_imm_d;
    logic [3:0]    alu_ctrl_q,  alu_ctrl_d;
    logic          reg_write_q, reg_write_d;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // ------------------------------------------------------------------------
    // Forwarding. r0 is never forwarded, so the stored value is used even if
    // a later stage claims to write r0. EX/MEM is younger than MEM/WB and
    // therefore wins. A bubble has both addresses at 0, so forwarding it is
    // harmless and needs no ex_valid qualification.
    // ------------------------------------------------------------------------
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_addr_q != '0) begin
            if (exmem_reg_write && (exmem_rd == rs_addr_q)) begin
                fwd_rs = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == rs_addr_q)) begin
                fwd_rs = memwb_result;
            end
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_addr_q != '0) begin
            if (exmem_reg_write && (exmem_rd == rt_addr_q)) begin
                fwd_rt = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == rt_addr_q)) begin
                fwd_rt = memwb_result;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state selection: flush > stall > load. Reset is applied in the
    // register block so that it overrides all of these.
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d     = valid_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_ctrl_d  = alu_ctrl_q;
        reg_write_d = reg_write_q;

        if (flush) begin
            valid_d     = 1'b0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            alu_ctrl_d  = 4'b0000;
            reg_write_d = 1'b0;
        end else if (stall) begin
            // While stalled, the operands are refreshed with their forwarded
            // values. A producer that retires out of MEM/WB during the stall
            // would otherwise vanish before this instruction reaches the ALU.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else begin
            valid_d     = id_valid;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            alu_ctrl_d  = id_alu_ctrl;
            reg_write_d = id_reg_write;
        end
    end

    // ------------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_ctrl_q  <= alu_ctrl_d;
            reg_write_q <= reg_write_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign src_A        = fwd_rs;
    assign src_B        = use_imm_q ? imm_q : fwd_rt;
    assign ex_rt_data   = fwd_rt;
    assign ALU_control  = alu_ctrl_q;
    assign ex_valid     = valid_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Directed, table-driven bench for ex_operand_stage. Each record drives one
// clock of inputs. The forwarding inputs stay applied while the outputs are
// sampled. Short hand-written sequences cover reset taking effect during a
// stall and during a flush.
// ----------------------------------------------------------------------------
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_use_imm;
    logic [3:0]    id_alu_ctrl;
    logic          id_reg_write;
    logic          stall, flush;
    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;
    logic [DW-1:0] src_A, src_B, ex_rt_data;
    logic [3:0]    ALU_control;
    logic          ex_valid;
    logic [RW-1:0] ex_rd_addr;
    logic          ex_reg_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_reg_write    (id_reg_write),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .src_A           (src_A),
        .src_B           (src_B),
        .ALU_control     (ALU_control),
        .ex_valid        (ex_valid),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_rt_data      (ex_rt_data)
    );

    typedef struct {
        string         name;
        // inputs
        logic          stall;
        logic          flush;
        logic          vld;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic [3:0]    ctrl;
        logic          we;
        logic          xm_we;
        logic [RW-1:0] xm_rd;
        logic [DW-1:0] xm_res;
        logic          wb_we;
        logic [RW-1:0] wb_rd;
        logic [DW-1:0] wb_res;
        // expected outputs after the clock
        logic [DW-1:0] e_src_a;
        logic [DW-1:0] e_src_b;
        logic [3:0]    e_ctrl;
        logic          e_valid;
        logic [RW-1:0] e_rd;
        logic          e_we;
        logic [DW-1:0] e_rt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 0; flush = 0;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0;
        id_alu_ctrl = 0; id_reg_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic apply(input vec_t v);
        stall = v.stall; flush = v.flush;
        id_valid = v.vld; id_rs_addr = v.rs; id_rt_addr = v.rt; id_rd_addr = v.rd;
        id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
        id_use_imm = v.use_imm; id_alu_ctrl = v.ctrl; id_reg_write = v.we;
        exmem_reg_write = v.xm_we; exmem_rd = v.xm_rd; exmem_result = v.xm_res;
        memwb_reg_write = v.wb_we; memwb_rd = v.wb_rd; memwb_result = v.wb_res;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " ex_valid"},     DW'(ex_valid),     '0);
        chk({tag, " ALU_control"},  DW'(ALU_control),  '0);
        chk({tag, " ex_rd_addr"},   DW'(ex_rd_addr),   '0);
        chk({tag, " ex_reg_write"}, DW'(ex_reg_write), '0);
        chk({tag, " src_A"},        src_A,             '0);
        chk({tag, " src_B"},        src_B,             '0);
    endtask

    initial begin
        //             name              st fl v  rs rt rd rs_data       rt_data       imm           ui ctrl we  xwe xrd xres          wwe wrd wres          eA            eB            ectl v  rd we  eRt
        vecs[0]  = '{"load_basic",       0, 0, 1, 3, 4, 6, 32'd10,       32'd20,       32'h0,        0, 4'h1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'd10,       32'd20,       4'h1, 1, 6, 1, 32'd20};
        vecs[1]  = '{"fwd_exmem_wins",   0, 0, 1, 5, 2, 8, 32'h11,       32'h22,       32'h0,        0, 4'h2, 1, 1, 5, 32'hAA,       1, 5, 32'hBB,       32'hAA,       32'h22,       4'h2, 1, 8, 1, 32'h22};
        // stall: exmem drops out, memwb now supplies rs; id_* junk is ignored
        vecs[2]  = '{"stall_fwd_memwb",  1, 0, 1, 9, 9, 9, 32'hDEAD,     32'hBEEF,     32'h5,        1, 4'hF, 0, 0, 5, 32'hAA,       1, 5, 32'hBB,       32'hBB,       32'h22,       4'h2, 1, 8, 1, 32'h22};
        vecs[3]  = '{"r0_not_fwd",       0, 0, 1, 0, 7, 9, 32'h33,       32'h44,       32'h0,        0, 4'h3, 1, 1, 0, 32'hAA,       1, 7, 32'h55,       32'h33,       32'h55,       4'h3, 1, 9, 1, 32'h55};
        vecs[4]  = '{"stall_capture",    1, 0, 1, 1, 1, 1, 32'h1,        32'h1,        32'h1,        1, 4'hE, 0, 0, 0, 32'h0,        1, 7, 32'h55,       32'h33,       32'h55,       4'h3, 1, 9, 1, 32'h55};
        // memwb retires during the stall: the captured value must survive
        vecs[5]  = '{"stall_retired",    1, 0, 1, 2, 2, 2, 32'h2,        32'h2,        32'h2,        1, 4'hD, 0, 0, 0, 32'h0,        0, 7, 32'h66,       32'h33,       32'h55,       4'h3, 1, 9, 1, 32'h55};
        vecs[6]  = '{"flush_and_stall",  1, 1, 1, 3, 4, 6, 32'h10,       32'h20,       32'h0,        0, 4'h1, 1, 1, 0, 32'hAA,       0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0};
        vecs[7]  = '{"use_imm",          0, 0, 1, 1, 4, 0, 32'h7,        32'h20,       32'hFFFFFFFC, 1, 4'h0, 0, 1, 4, 32'h99,       0, 0, 32'h0,        32'h7,        32'hFFFFFFFC, 4'h0, 1, 0, 0, 32'h99};
        vecs[8]  = '{"invalid_no_we",    0, 0, 0, 2, 3, 3, 32'h5,        32'h6,        32'h0,        0, 4'h4, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h5,        32'h6,        4'h4, 0, 3, 0, 32'h6};
        vecs[9]  = '{"full_width",       0, 0, 1, 31, 30, 31, 32'hDEADBEEF, 32'h80000001, 32'h0,     0, 4'hF, 1, 0, 31, 32'h1,       1, 30, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 4'hF, 1, 31, 1, 32'hFFFFFFFF};
        vecs[10] = '{"flush_alone",      0, 1, 1, 5, 5, 5, 32'h9,        32'h9,        32'h9,        1, 4'h9, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0};

        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " src_A"},        src_A,              vecs[i].e_src_a);
            chk({vecs[i].name, " src_B"},        src_B,              vecs[i].e_src_b);
            chk({vecs[i].name, " ALU_control"},  DW'(ALU_control),   DW'(vecs[i].e_ctrl));
            chk({vecs[i].name, " ex_valid"},     DW'(ex_valid),      DW'(vecs[i].e_valid));
            chk({vecs[i].name, " ex_rd_addr"},   DW'(ex_rd_addr),    DW'(vecs[i].e_rd));
            chk({vecs[i].name, " ex_reg_write"}, DW'(ex_reg_write),  DW'(vecs[i].e_we));
            chk({vecs[i].name, " ex_rt_data"},   ex_rt_data,         vecs[i].e_rt);
            @(negedge clk);
        end

        // Reset during a stall: load a real instruction, then assert stall and reset together.
        drive_idle();
        id_valid = 1; id_rs_addr = 3; id_rt_addr = 4; id_rd_addr = 6;
        id_rs_data = 32'h10; id_rt_data = 32'h20; id_alu_ctrl = 4'h5; id_reg_write = 1;
        @(posedge clk); #1;
        chk("pre_rst_stall ex_valid", DW'(ex_valid), 1);
        @(negedge clk);
        stall = 1; reset = 1;
        @(posedge clk); #1;
        check_reset_state("rst_in_stall");
        @(negedge clk);

        // Reset during a flush: reload, then assert flush and reset together.
        reset = 0; stall = 0;
        @(posedge clk); #1;
        chk("pre_rst_flush ALU_control", DW'(ALU_control), 5);
        @(negedge clk);
        flush = 1; reset = 1;
        @(posedge clk); #1;
        check_reset_state("rst_in_flush");
        @(negedge clk);
        reset = 0; flush = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
